// File: rtl/meas_frame_packer.sv
// meas_frame_packer
// Snapshots NCH measurement channels on a frame trigger. It then streams one
// header word, one record word per valid channel and, optionally, an XOR
// checksum word over a valid/ready interface.
// Optional feature macro: CHECKSUM_EN appends the checksum word to each frame.
module meas_frame_packer #(
    parameter  int NCH  = 4,
    parameter  int HT_W = 16,
    parameter  int AT_W = 16,
    parameter  int FX_W = 32,
    localparam int DW   = HT_W + AT_W + FX_W
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 trig,
    input  logic [NCH-1:0]       meas_vld,
    input  logic [NCH*HT_W-1:0]  high_times,
    input  logic [NCH*AT_W-1:0]  all_times,
    input  logic [NCH*FX_W-1:0]  fx,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_drop
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    // The header needs 32 bits of tag/sequence above the channel mask.
    if (DW < 32 + NCH) begin : g_bad_dw
        $error("meas_frame_packer: DW must be at least 32+NCH");
    end
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
        $error("meas_frame_packer: NCH must be in 1..32");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
`ifdef CHECKSUM_EN
        , S_CSUM = 2'd3
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [HT_W-1:0]  r_snap_ht [NCH];
    logic [AT_W-1:0]  r_snap_at [NCH];
    logic [FX_W-1:0]  r_snap_fx [NCH];
    logic [NCH-1:0]   r_mask;
    logic [NCH-1:0]   r_pend;
    logic [15:0]      r_seq;
    logic [DW-1:0]    r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_drop;
`ifdef CHECKSUM_EN
    logic [DW-1:0]    r_csum;
`endif

    logic             w_hs;
    logic             w_accept;
    logic [NCH-1:0]   w_pick_src;
    logic [NCH-1:0]   w_pick_rest;
    logic [IW-1:0]    w_idx;
    logic [DW-1:0]    w_rec;
    logic [DW-1:0]    w_hdr;
    logic [DW-1:0]    w_data_nxt;
    logic             w_valid_nxt;
    logic             w_last_nxt;
    logic [NCH-1:0]   w_pend_nxt;
    logic             w_load_rec;

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign frame_drop = r_drop;
    assign busy       = (r_state != S_IDLE);

    // Handshake and trigger acceptance; a trigger on the final-word handshake starts the next frame.
    always_comb begin
        w_hs       = r_out_valid & out_ready;
        w_accept   = trig & ((r_state == S_IDLE) | (w_hs & r_out_last));
        // The header state walks the full mask; the data state walks the remaining bits.
        w_pick_src = (r_state == S_HDR) ? r_mask : r_pend;
        w_pick_rest = w_pick_src & (w_pick_src - NCH'(1));
    end

    // Lowest set channel of the pick source, and its record word.
    always_comb begin
        w_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_pick_src[i]) w_idx = IW'(i);
        end
        w_rec = {r_snap_ht[w_idx], r_snap_at[w_idx], r_snap_fx[w_idx]};
    end

    // Header for a frame accepted this cycle, built from the live seq and meas_vld.
    always_comb begin
        w_hdr              = '0;
        w_hdr[DW-1 -: 16]  = 16'hA55A;
        w_hdr[DW-17 -: 16] = r_seq;
        w_hdr[NCH-1:0]     = meas_vld;
    end

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_data_nxt  = r_out_data;
        w_valid_nxt = r_out_valid;
        w_last_nxt  = r_out_last;
        w_pend_nxt  = r_pend;
        w_load_rec  = 1'b0;
        case (r_state)
            S_HDR, S_DATA: begin
                if (w_hs) begin
                    if (w_pick_src != '0) begin
                        w_state_nxt = S_DATA;
                        w_load_rec  = 1'b1;
                        w_data_nxt  = w_rec;
                        w_pend_nxt  = w_pick_rest;
                        w_last_nxt  = (w_pick_rest == '0) & ~CSUM_ON;
                    end else begin
`ifdef CHECKSUM_EN
                        w_state_nxt = S_CSUM;
                        w_data_nxt  = r_csum;
                        w_last_nxt  = 1'b1;
`else
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                end
            end
`endif
            default: begin
            end
        endcase
        if (w_accept) begin
            w_state_nxt = S_HDR;
            w_data_nxt  = w_hdr;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (meas_vld == '0) & ~CSUM_ON;
        end
    end

    // State, stream output registers, sequence counter and drop pulse.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pend      <= '0;
            r_seq       <= '0;
            r_drop      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
            r_state     <= w_state_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_pend      <= w_pend_nxt;
            r_drop      <= trig & ~w_accept;
            if (w_accept) r_seq <= r_seq + 16'd1;
        end
    end

    // Snapshot bank: captured only on an accepted trigger, held for the whole frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the snapshot bank is reset deliberately so a frame abandoned by reset leaves no stale channel data.
            for (int i = 0; i < NCH; i++) begin
                r_snap_ht[i] <= '0;
                r_snap_at[i] <= '0;
                r_snap_fx[i] <= '0;
            end
            r_mask <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NCH; i++) begin
                r_snap_ht[i] <= high_times[i*HT_W +: HT_W];
                r_snap_at[i] <= all_times[i*AT_W +: AT_W];
                r_snap_fx[i] <= fx[i*FX_W +: FX_W];
            end
            r_mask <= meas_vld;
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR of every word loaded into the stream; it restarts from the header of each accepted frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= w_hdr;
        end else if (w_load_rec) begin
            r_csum <= r_csum ^ w_rec;
        end
    end
`endif

endmodule

// File: tb/tb_meas_frame_packer.sv
// Testbench for meas_frame_packer: a fixed-vector table for the first frame,
// then directed and random sequences. Each sequence is compared cycle by cycle
// against a frame-level queue model built from the framing rules.
module tb_meas_frame_packer;

    localparam int NCH  = 4;
    localparam int HT_W = 16;
    localparam int AT_W = 16;
    localparam int FX_W = 32;
    localparam int DW   = HT_W + AT_W + FX_W;

`ifdef CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic                sys_clk = 1'b0;
    logic                rst_n   = 1'b1;
    logic                trig    = 1'b0;
    logic [NCH-1:0]      meas_vld = '0;
    logic [NCH*HT_W-1:0] high_times = '0;
    logic [NCH*AT_W-1:0] all_times  = '0;
    logic [NCH*FX_W-1:0] fx         = '0;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_ready = 1'b0;
    logic                busy;
    logic                frame_drop;

    meas_frame_packer #(.NCH(NCH), .HT_W(HT_W), .AT_W(AT_W), .FX_W(FX_W)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .meas_vld  (meas_vld),
        .high_times(high_times),
        .all_times (all_times),
        .fx        (fx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_drop(frame_drop)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } word_t;

    typedef struct {
        bit             trig;
        logic [NCH-1:0] vld;
        bit             ready;
        bit             exp_valid;
        logic [DW-1:0]  exp_data;
        bit             exp_last;
    } vec_t;

    word_t       exp_q[$];
    vec_t        tbl[$];
    logic [15:0] m_seq  = 16'd0;
    bit          m_drop = 1'b0;
    int          n_vec  = 0;
    int          n_err  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected words of one frame, straight from the framing rules.
    function automatic void push_frame(input logic [NCH-1:0] v);
        word_t         f[$];
        word_t         w;
        logic [DW-1:0] x;
        w.d = '0;
        w.d[DW-1 -: 16]  = 16'hA55A;
        w.d[DW-17 -: 16] = m_seq;
        w.d[NCH-1:0]     = v;
        w.last = 1'b0;
        f.push_back(w);
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) begin
                w.d = {high_times[i*HT_W +: HT_W], all_times[i*AT_W +: AT_W], fx[i*FX_W +: FX_W]};
                f.push_back(w);
            end
        end
`ifdef CHECKSUM_EN
        x = '0;
        foreach (f[k]) x ^= f[k].d;
        w.d = x;
        f.push_back(w);
`else
        x = '0;
`endif
        f[f.size()-1].last = 1'b1;
        foreach (f[k]) exp_q.push_back(f[k]);
        m_seq = m_seq + 16'd1;
    endfunction

    task automatic compare_outputs();
        check("valid", out_valid, (exp_q.size() != 0));
        check("busy", busy, (exp_q.size() != 0));
        check("frame_drop", frame_drop, m_drop);
        if (exp_q.size() != 0) begin
            check("data", out_data, exp_q[0].d);
            check("last", out_last, exp_q[0].last);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, compare at the next falling edge.
    task automatic step(input bit t, input logic [NCH-1:0] v, input bit r);
        bit hs, fin, acc;
        trig = t; meas_vld = v; out_ready = r;
        hs  = (exp_q.size() != 0) && r;
        fin = hs && exp_q[0].last;
        acc = t && ((exp_q.size() == 0) || fin);
        if (hs) void'(exp_q.pop_front());
        if (acc) push_frame(v);
        m_drop = t && !acc;
        @(posedge sys_clk);
        @(negedge sys_clk);
        compare_outputs();
    endtask

    task automatic rand_chan();
        high_times = {$urandom, $urandom};
        all_times  = {$urandom, $urandom};
        fx         = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, '0, 1'b1);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        exp_q.delete();
        m_seq  = 16'd0;
        m_drop = 1'b0;
        trig   = 1'b0;
        #1;
        check("rst_data", out_data, '0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", frame_drop, 1'b0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    function automatic void add_vec(input bit t, input logic [NCH-1:0] v, input bit r,
                                    input bit ev, input logic [DW-1:0] ed, input bit el);
        vec_t x;
        x.trig = t; x.vld = v; x.ready = r;
        x.exp_valid = ev; x.exp_data = ed; x.exp_last = el;
        tbl.push_back(x);
    endfunction

    initial begin
        do_reset();

        // First frame after reset: all four channels, fixed data, seq 0.
        high_times = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        all_times  = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
        fx         = {32'h0000_1003, 32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
        add_vec(1'b1, 4'hF, 1'b1, 1'b1, 64'hA55A_0000_0000_000F, 1'b0);
        add_vec(1'b0, 4'h0, 1'b1, 1'b1, 64'h0010_0040_0000_1000, 1'b0);
        add_vec(1'b0, 4'h0, 1'b1, 1'b1, 64'h0011_0041_0000_1001, 1'b0);
        add_vec(1'b0, 4'h0, 1'b1, 1'b1, 64'h0012_0042_0000_1002, 1'b0);
        add_vec(1'b0, 4'h0, 1'b1, 1'b1, 64'h0013_0043_0000_1003, !CSUM);
`ifdef CHECKSUM_EN
        // Records XOR to zero, so the checksum equals the header.
        add_vec(1'b0, 4'h0, 1'b1, 1'b1, 64'hA55A_0000_0000_000F, 1'b1);
`endif
        add_vec(1'b0, 4'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        foreach (tbl[k]) begin
            step(tbl[k].trig, tbl[k].vld, tbl[k].ready);
            check("tbl_valid", out_valid, tbl[k].exp_valid);
            if (tbl[k].exp_valid) begin
                check("tbl_data", out_data, tbl[k].exp_data);
                check("tbl_last", out_last, tbl[k].exp_last);
            end
        end

        // Sparse mask: header mask 5, records ch0 then ch2, seq 1.
        rand_chan();
        step(1'b1, 4'b0101, 1'b1);
        drain();

        // Random back-pressure and changing inputs during a four-record frame.
        rand_chan();
        step(1'b1, 4'hF, 1'b1);
        for (int k = 0; k < 30; k++) begin
            rand_chan();
            step(1'b0, 4'($urandom), 1'($urandom));
        end
        drain();

        // Trigger during DATA is dropped; trigger on the final handshake is accepted.
        rand_chan();
        step(1'b1, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'h3, 1'b1);
        for (int k = 0; k < 20 && !(exp_q.size() == 1 && exp_q[0].last); k++) step(1'b0, 4'h0, 1'b1);
        rand_chan();
        step(1'b1, 4'b1010, 1'b1);
        drain();

        // Empty mask: single-word frames; run seq around its wrap.
        for (int k = 0; k < 70000 && m_seq != 16'hFFFF; k++) begin
`ifdef CHECKSUM_EN
            step(1'b1, 4'h0, 1'b1);
            step(1'b0, 4'h0, 1'b1);
`else
            step(1'b1, 4'h0, 1'b1);
`endif
        end
        check("seq_reached_ffff", m_seq, 16'hFFFF);
        step(1'b1, 4'h0, 1'b1);
        drain();
        step(1'b1, 4'h0, 1'b1);
        drain();

        // Checksum-sized frame with mask 0011.
        rand_chan();
        step(1'b1, 4'b0011, 1'b1);
        drain();

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            rand_chan();
            step(($urandom_range(0, 5) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain();

        // Reset in the middle of a frame, then a fresh frame restarts at seq 0.
        rand_chan();
        step(1'b1, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        do_reset();
        compare_outputs();
        rand_chan();
        step(1'b1, 4'b0110, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
